// File: rtl/binary_to_bcd_if.sv
// Start/busy/done handshake and result bus between a requester and binary_to_bcd.
// The master drives the request; the slave (the converter) drives the registered result.
interface binary_to_bcd_if #(
   parameter int SEL_BITS = 2,
   parameter int BIN_BITS = 14
);
   logic                       start;
   logic [BIN_BITS-1:0]        value;
   logic                       busy;
   logic                       done;
   logic [(4<<SEL_BITS)-1:0]   code;
   logic                       overflow;
   logic                       negative;

   modport master (
      output start, value,
      input  busy, done, code, overflow, negative
   );

   modport slave (
      input  start, value,
      output busy, done, code, overflow, negative
   );
endinterface

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble binary to packed-BCD converter feeding the seven-segment display.
// Optional two's-complement input when BINARY_TO_BCD_SIGNED_EN is defined.
module binary_to_bcd #(
   parameter int SEL_BITS = 2,
   parameter int BIN_BITS = 14
) (
   input  logic           clk,
   input  logic           nreset,
   binary_to_bcd_if.slave bus
);
   localparam int NDIG = 1 << SEL_BITS;
   localparam int DW   = 4 * NDIG;
   localparam int CW   = $clog2(BIN_BITS + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

   state_t              state_q;
   logic [BIN_BITS-1:0] bin_q, bin_d, mag;
   logic [DW-1:0]       scr_q, scr_d, adj, code_q;
   logic [CW-1:0]       cnt_q;
   logic                sticky_q, busy_q, done_q, ovf_q;

   // Add-3 correction on every digit in parallel before the shift.
   for (genvar k = 0; k < NDIG; k++) begin : g_adj
      assign adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3
                                                       : scr_q[4*k +: 4];
   end

   // The bit leaving the top digit (adj[DW-1]) means the value no longer fits.
   assign {scr_d, bin_d} = {adj[DW-2:0], bin_q, 1'b0};

`ifdef BINARY_TO_BCD_SIGNED_EN
   logic sign_in, sign_q, neg_q;
   assign sign_in = bus.value[BIN_BITS-1];
   // Magnitude taken as unsigned so -2^(BIN_BITS-1) still converts correctly.
   assign mag     = sign_in ? (~bus.value) + {{(BIN_BITS-1){1'b0}}, 1'b1} : bus.value;
   assign bus.negative = neg_q;
`else
   assign mag          = bus.value;
   assign bus.negative = 1'b0;
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         scr_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         code_q   <= '0;
         ovf_q    <= 1'b0;
`ifdef BINARY_TO_BCD_SIGNED_EN
         sign_q   <= 1'b0;
         neg_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  bin_q    <= mag;
                  scr_q    <= '0;
                  sticky_q <= 1'b0;
                  cnt_q    <= CW'(BIN_BITS);
                  busy_q   <= 1'b1;
                  state_q  <= CONVERT;
`ifdef BINARY_TO_BCD_SIGNED_EN
                  sign_q   <= sign_in;
`endif
               end
            end
            CONVERT: begin
               scr_q <= scr_d;
               bin_q <= bin_d;
               if (adj[DW-1]) sticky_q <= 1'b1;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               code_q  <= sticky_q ? '1 : scr_q;
               ovf_q   <= sticky_q;
               done_q  <= 1'b1;
               state_q <= IDLE;
`ifdef BINARY_TO_BCD_SIGNED_EN
               neg_q   <= sign_q;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.code     = code_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd: a cycle model predicts acceptance, busy and done timing,
// and expected results are queued on acceptance and compared when done pulses.
module tb_binary_to_bcd;
   localparam int SEL_BITS = 2;
   localparam int BIN_BITS = 14;

   typedef struct {
      logic [15:0] code;
      logic        ovf;
      logic        neg;
      int          dcyc;
   } exp_t;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   mcnt = 0;
   exp_t exp_q[$];
   logic [15:0] last_code = '0;
   logic        last_ovf = 1'b0;
   logic        last_neg = 1'b0;

   binary_to_bcd_if #(.SEL_BITS(SEL_BITS), .BIN_BITS(BIN_BITS)) bus();

   binary_to_bcd #(.SEL_BITS(SEL_BITS), .BIN_BITS(BIN_BITS)) dut (
      .clk   (clk),
      .nreset(nreset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [13:0] v, input int dcyc);
      exp_t e;
      logic [13:0] m;
      int          n;
`ifdef BINARY_TO_BCD_SIGNED_EN
      e.neg = v[13];
      m     = v[13] ? 14'(-v) : v;
`else
      e.neg = 1'b0;
      m     = v;
`endif
      n = int'(m);
      e.ovf  = (n > 9999);
      e.code = e.ovf ? 16'hFFFF
             : {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
      e.dcyc = dcyc;
      return e;
   endfunction

   // Acceptance model: idle when mcnt==0; a conversion occupies BIN_BITS+2 edges.
   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         mcnt <= 0;
         exp_q.delete();
      end else begin
         cyc <= cyc + 1;
         if (mcnt != 0) mcnt <= mcnt - 1;
         else if (bus.start) begin
            exp_q.push_back(model(bus.value, cyc + 1 + BIN_BITS + 1));
            mcnt <= BIN_BITS + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!nreset) begin
         last_code = '0;
         last_ovf  = 1'b0;
         last_neg  = 1'b0;
      end else begin
         chk("busy", bus.busy, mcnt >= 2);
         if (bus.done) begin
            if (exp_q.size() == 0) chk("spurious_done", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("done_cycle", cyc, e.dcyc);
               chk("code", bus.code, e.code);
               chk("overflow", bus.overflow, e.ovf);
               chk("negative", bus.negative, e.neg);
               last_code = e.code;
               last_ovf  = e.ovf;
               last_neg  = e.neg;
            end
         end else begin
            if (exp_q.size() != 0 && exp_q[0].dcyc == cyc) chk("done_missing", 0, 1);
            chk("hold_code", bus.code, last_code);
            chk("hold_ovf", bus.overflow, last_ovf);
            chk("hold_neg", bus.negative, last_neg);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0 && mcnt == 0) break;
         @(negedge clk);
      end
      chk("idle_timeout", (exp_q.size() == 0 && mcnt == 0), 1);
   endtask

   task automatic conv(input logic [13:0] v);
      @(negedge clk);
      bus.value = v;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
   endtask

   initial begin
      bus.start = 1'b0;
      bus.value = '0;
      repeat (3) @(negedge clk);
      chk("rst_code", bus.code, 16'h0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_neg", bus.negative, 0);
      nreset = 1'b1;

      conv(14'd1234);
      conv(14'd9999);
      conv(14'd10000);
      conv(14'd0);

      // A second start while busy must be ignored, as must the value change.
      @(negedge clk);
      bus.value = 14'd42;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.value = 14'd777;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      conv(14'd777);

      // Abort mid-conversion.
      @(negedge clk);
      bus.value = 14'd5555;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 nreset = 1'b0;
      #1;
      chk("abort_code", bus.code, 16'h0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_ovf", bus.overflow, 0);
      chk("abort_neg", bus.negative, 0);
      repeat (2) @(negedge clk);
      #2 nreset = 1'b1;
      repeat (20) @(negedge clk);
      conv(14'd5555);

      // Start held high: back-to-back conversions every BIN_BITS+2 cycles.
      @(negedge clk);
      bus.value = 14'd16383;
      bus.start = 1'b1;
      repeat (64) @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      conv(14'h3FFF);
      conv(14'h2000);
      conv(14'h0000);
      conv(14'd1);
      conv(14'd9990);

      for (int i = 0; i < 16; i++) conv(14'($urandom_range(0, 16383)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
